ms_serial_mul_nway: RTL and testbench
=====================================

Name: ms_serial_mul_nway

Overview:
- Deterministic stochastic-computing (DSC) multiplier for NUM_INPUTS unsigned operands of DATA_WIDTH bits each; returns their exact product.
- Each operand drives a stride-2 unary digit counter that emits 2 bits per cycle. The counters are chained with enables on one clock; there is no ripple clocking.
- Each cycle, 2^NUM_INPUTS AND lanes are popcounted into an accumulator.
- A start/busy/done handshake lets the arch-sweep top reuse the block back-to-back.

Parameters:
- DATA_WIDTH, 5: operand width W; legal range 2..8.
- NUM_INPUTS, 2: operand count N; legal range 1..6.
- OUT_WIDTH, DATA_WIDTH*NUM_INPUTS: result width; always holds (2^W-1)^N.
- CYC_WIDTH, (DATA_WIDTH-1)*NUM_INPUTS+1: width of the cycle counter.

Ports:
- clk, in, 1: single clock; all logic on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- en, in, 1: advance enable; when low in RUN, all state holds.
- start, in, 1: request; accepted only in IDLE.
- op_in, in, NUM_INPUTS*DATA_WIDTH: operands, flattened; operand i is op_in[i*W +: W].
- busy, out, 1: high in RUN and DONE.
- done, out, 1: one-cycle pulse when result is valid.
- result, out, OUT_WIDTH: product; held until the next accepted start.
- cyc_cnt, out, CYC_WIDTH: number of RUN cycles consumed by the last operation.

Behaviour:
- Reset: on rst=1 at a clock edge, the next state is:
  - state=IDLE; busy=0, done=0, result=0, cyc_cnt=0;
  - all digit counters=0.
  - This applies equally mid-operation: the operation is abandoned and no done is issued.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1. Operands are latched into x_i; the accumulator, cyc_cnt and counters are cleared.
  - RUN -> DONE on the terminal cycle, which is the cycle that must have en=1.
  - DONE -> IDLE unconditionally after 1 cycle.
  - start is ignored outside IDLE.
- Digit counter i: c_i takes values 0, 2, ..., 2^W-2. It emits bit j (j=0,1) = ((c_i + j) < x_i).
- Counter advance, in a RUN cycle with en=1:
  - c_0 always steps by 2.
  - c_i steps only when every c_k with k<i equals 2^W-2.
  - A counter at 2^W-2 wraps to 0 when it steps.
- Lane L (0..2^N-1) = AND over i of (bit L[N-1-i] of counter i).
- Accumulation: every RUN cycle with en=1 does acc += popcount(lanes) and cyc_cnt += 1.
- Terminal cycle: all c_i = 2^W-2, with en=1.
- Run length: R = 2^((W-1)*N) RUN cycles. The final accumulation lands in result on the edge leaving RUN.
- Latency: with start accepted at edge k and en held high, done=1 in the cycle following edge k+R.
- Exactness: result = product of x_i. Any zero operand gives result = 0.
- en low: holds counters, accumulator, cyc_cnt and state. done never asserts while en=0 in RUN.
- start with rst in the same cycle: rst wins.

Optional Feature:
- Macro: MS_SERIAL_MUL_EARLY_TERM_EN.
- With the macro defined, a RUN cycle (en=1) is also terminal if either condition holds:
  - any x_i == 0, or
  - c_{N-1} >= x_{N-1}.
  - Such a cycle contributes 0, because all remaining lanes are zero.
  - Resulting cyc_cnt: 1 if any operand is zero; otherwise min(R, ceil(x_{N-1}/2)*2^((W-1)(N-1)) + 1).
  - result is unchanged, i.e. still exact.
- Without the macro, every operation takes exactly R RUN cycles.

Decomposition:
- Package ms_sc_pkg holds:
  - state enum (IDLE/RUN/DONE);
  - a function computing the lane count 2^N;
  - constant functions for OUT_WIDTH and CYC_WIDTH;
  - a popcount function.
- Sub-module ms_dsc_digit_ctr: one stride-2 counter with step-in enable, at-max (carry) out, and a 2-bit unary output comparator against a latched operand. It is instantiated N times in a generate loop; the carry chain is wired in the top.

Test Plan:
- W=4, N=2, ops 5,3, no macro -> done after 64 RUN cycles, result=15, cyc_cnt=64, busy high for 65 cycles.
- W=4, N=2, ops 5,3, macro on -> result=15, cyc_cnt=17. Ops 7,15 -> result=105, cyc_cnt=64.
- W=5, N=3, ops 31,31,31 -> result=29791, cyc_cnt=4096. Any zero operand -> result=0; with the macro, cyc_cnt=1.
- Toggle en low for 10 random cycles mid-run (W=4, N=2, ops 9,6) -> result=54, cyc_cnt=64, done delayed by exactly 10 cycles.
- Assert rst at RUN cycle 20, then start with ops 2,2 -> no done for the aborted run; second run gives result=4.
- Pulse start during busy with different ops -> ignored; result matches the first operands. Then back-to-back start in the cycle after done -> accepted.

Source files
------------

// File: rtl/ms_sc_pkg.sv
// Shared types and helpers for the deterministic stochastic-computing
// serial multiplier: FSM state encoding, lane/width arithmetic, popcount.
package ms_sc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sc_state_e;

  // Widest lane vector the popcount has to handle (NUM_INPUTS up to 6).
  localparam int SC_MAX_LANES = 64;

  // Number of AND lanes for n operands.
  function automatic int sc_lane_cnt(input int n);
    return 1 << n;
  endfunction

  // Result width that always holds (2^w-1)^n.
  function automatic int sc_out_width(input int w, input int n);
    return w * n;
  endfunction

  // Cycle counter width that holds the full run length 2^((w-1)*n).
  function automatic int sc_cyc_width(input int w, input int n);
    return (w - 1) * n + 1;
  endfunction

  // Number of set bits in a lane vector.
  function automatic logic [6:0] sc_popcount(input logic [SC_MAX_LANES-1:0] v);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < SC_MAX_LANES; i++) begin
      cnt = cnt + 7'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ms_dsc_digit_ctr.sv
// One stride-2 unary digit counter. Holds a latched operand x and a count
// c in {0, 2, ..., 2^W-2}; emits two unary bits (c+j) < x per cycle.
// The carry chain between counters lives in the parent.
module ms_dsc_digit_ctr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] x_in,
  input  logic         step,
  output logic         at_max,
  output logic [1:0]   ubits,
  output logic         spent,
  output logic         x_zero
);

  localparam logic [W-1:0] C_MAX = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0] c_q;
  logic [W-1:0] x_q;

  // Operand latch and stride-2 count; load has priority over step.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
      x_q <= '0;
    end else if (load) begin
      c_q <= '0;
      x_q <= x_in;
    end else if (step) begin
      c_q <= at_max ? '0 : c_q + W'(2);
    end
  end

  assign at_max   = (c_q == C_MAX);

  // Widened compare so c+1 never wraps at the top of the range.
  assign ubits[0] = ({1'b0, c_q} < {1'b0, x_q});
  assign ubits[1] = (({1'b0, c_q} + (W+1)'(1)) < {1'b0, x_q});

  // Once c has reached x, every later pair of bits from this counter is 0.
  assign spent    = (c_q >= x_q);
  assign x_zero   = (x_q == '0);

endmodule

// File: rtl/ms_serial_mul_nway.sv
// Deterministic stochastic-computing multiplier for NUM_INPUTS unsigned
// operands. N chained stride-2 digit counters produce 2 unary bits each
// per cycle; 2^N AND lanes are popcounted into an accumulator that ends
// up holding the exact product.
//
// Optional build macro: MS_SERIAL_MUL_EARLY_TERM_EN
//   Ends the run as soon as the remaining lanes are provably all zero
//   (a zero operand, or the most significant counter has passed its
//   operand). The result stays exact; only cyc_cnt shrinks.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; result/cyc_cnt hold the last operation
// ST_RUN  | counting and accumulating on every cycle with en=1
// ST_DONE | one-cycle done pulse; result valid
module ms_serial_mul_nway
  import ms_sc_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int OUT_WIDTH  = sc_out_width(DATA_WIDTH, NUM_INPUTS),
  parameter int CYC_WIDTH  = sc_cyc_width(DATA_WIDTH, NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             start,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] op_in,
  output logic                             busy,
  output logic                             done,
  output logic [OUT_WIDTH-1:0]             result,
  output logic [CYC_WIDTH-1:0]             cyc_cnt
);

  localparam int W     = DATA_WIDTH;
  localparam int N     = NUM_INPUTS;
  localparam int LANES = sc_lane_cnt(NUM_INPUTS);

  sc_state_e state_q;
  sc_state_e state_d;

  logic accept;
  logic adv;
  logic term;
  logic full_term;
  logic early_term;

  logic [N-1:0]      at_max;
  logic [N-1:0]      gate;
  logic [N-1:0]      step;
  logic [N-1:0]      spent;
  logic [N-1:0]      x_zero;
  logic [N-1:0][1:0] ubits;

  logic [LANES-1:0]     lanes;
  logic [6:0]           pop;
  logic [OUT_WIDTH-1:0] acc_q;
  logic [OUT_WIDTH-1:0] acc_next;

  assign accept = (state_q == ST_IDLE) && start;
  assign adv    = (state_q == ST_RUN) && en;

  // Counter i steps only when every lower counter sits at its maximum.
  for (genvar i = 0; i < N; i++) begin : g_ctr
    if (i == 0) begin : g_first
      assign gate[i] = 1'b1;
    end else begin : g_rest
      assign gate[i] = &at_max[i-1:0];
    end

    assign step[i] = adv & gate[i];

    ms_dsc_digit_ctr #(
      .W (W)
    ) u_ctr (
      .clk    (clk),
      .rst    (rst),
      .load   (accept),
      .x_in   (op_in[i*W +: W]),
      .step   (step[i]),
      .at_max (at_max[i]),
      .ubits  (ubits[i]),
      .spent  (spent[i]),
      .x_zero (x_zero[i])
    );
  end

  // Lane L takes bit L[N-1-i] from counter i; selectors are elaboration
  // constants so each lane is a plain AND tree.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [N-1:0] terms;
    for (genvar i = 0; i < N; i++) begin : g_term
      localparam int SEL = (l >> (N - 1 - i)) & 1;
      assign terms[i] = ubits[i][SEL];
    end
    assign lanes[l] = &terms;
  end

  assign pop      = sc_popcount(SC_MAX_LANES'(lanes));
  assign acc_next = acc_q + OUT_WIDTH'(pop);

  assign full_term = &at_max;

`ifdef MS_SERIAL_MUL_EARLY_TERM_EN
  assign early_term = (|x_zero) | spent[N-1];
`else
  logic early_unused;
  assign early_unused = ^{spent, x_zero};
  assign early_term   = 1'b0;
`endif

  assign term = adv & (full_term | early_term);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (term)  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Accumulator, cycle count and result capture on the terminal cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      cyc_cnt <= '0;
      result  <= '0;
    end else if (accept) begin
      acc_q   <= '0;
      cyc_cnt <= '0;
    end else if (adv) begin
      acc_q   <= acc_next;
      cyc_cnt <= cyc_cnt + CYC_WIDTH'(1);
      if (term) begin
        result <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_ms_serial_mul_nway.sv
module tb_ms_serial_mul_nway;

  localparam int W  = 4;
  localparam int N  = 2;
  localparam int OW = W * N;
  localparam int CW = (W - 1) * N + 1;
  localparam int R  = 1 << ((W - 1) * N);
  localparam int TIMEOUT = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          start;
  logic [N*W-1:0] op_in;
  logic          busy;
  logic          done;
  logic [OW-1:0] result;
  logic [CW-1:0] cyc_cnt;

  int n_vec = 0;
  int n_err = 0;

  ms_serial_mul_nway #(
    .DATA_WIDTH (W),
    .NUM_INPUTS (N)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .start   (start),
    .op_in   (op_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .cyc_cnt (cyc_cnt)
  );

  always #5 clk = ~clk;

  // Reference run length: full R cycles, or the early-exit count when built
  // with early termination (b is the most significant operand).
  function automatic int exp_cyc(input int a, input int b);
    int e;
    e = R;
`ifdef MS_SERIAL_MUL_EARLY_TERM_EN
    if (a == 0 || b == 0) e = 1;
    else if (((b + 1) / 2) * (1 << ((W - 1) * (N - 1))) + 1 < R)
      e = ((b + 1) / 2) * (1 << ((W - 1) * (N - 1))) + 1;
`else
    if (a < 0 || b < 0) e = 0;
`endif
    return e;
  endfunction

  // Starts one operation at the current negedge and waits for done.
  // n_low cycles of en=0 are scattered before hi_cap advancing cycles;
  // at poke_at a different start request is driven while busy.
  task automatic do_op(input int a, input int b, input int n_low, input int hi_cap,
                       input int poke_at, output int lat, output bit busy_ok);
    int lows;
    int highs;
    lows    = n_low;
    highs   = 0;
    lat     = 0;
    busy_ok = 1'b1;
    en      = 1'b1;
    start   = 1'b1;
    op_in   = {4'(b), 4'(a)};
    @(negedge clk);
    start = 1'b0;
    while (!done && lat < TIMEOUT) begin
      if (!busy) busy_ok = 1'b0;
      if (lat == poke_at) begin
        start = 1'b1;
        op_in = 8'($urandom_range(0, 255));
      end else begin
        start = 1'b0;
      end
      if (lows > 0 && highs >= 1 && (highs >= hi_cap || $urandom_range(0, 3) == 0)) begin
        en = 1'b0;
        lows--;
      end else begin
        en = 1'b1;
        highs++;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    en    = 1'b1;
    if (!busy) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    en    = 1'b1;
    op_in = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
    n_vec++;
    if (result !== '0) begin n_err++; $display("FAIL reset_result got=%0d want=0", result); end
    n_vec++;
    if (cyc_cnt !== '0) begin n_err++; $display("FAIL reset_cyc got=%0d want=0", cyc_cnt); end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
  endtask

  // One operation with full result/cycle/latency/handshake checking.
  task automatic run_checked(input string tag, input int a, input int b);
    int lat;
    bit bok;
    do_op(a, b, 0, R, -1, lat, bok);
    n_vec++;
    if (result !== OW'(a * b)) begin n_err++; $display("FAIL %s_result a=%0d b=%0d got=%0d want=%0d", tag, a, b, result, a * b); end
    n_vec++;
    if (cyc_cnt !== CW'(exp_cyc(a, b))) begin n_err++; $display("FAIL %s_cyc a=%0d b=%0d got=%0d want=%0d", tag, a, b, cyc_cnt, exp_cyc(a, b)); end
    n_vec++;
    if (lat != exp_cyc(a, b)) begin n_err++; $display("FAIL %s_latency a=%0d b=%0d got=%0d want=%0d", tag, a, b, lat, exp_cyc(a, b)); end
    n_vec++;
    if (!bok) begin n_err++; $display("FAIL %s_busy_span a=%0d b=%0d got=dropped want=held", tag, a, b); end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL %s_pulse got done=%b busy=%b want 0/0", tag, done, busy); end
    n_vec++;
    if (result !== OW'(a * b)) begin n_err++; $display("FAIL %s_hold got=%0d want=%0d", tag, result, a * b); end
  endtask

  task automatic test_directed();
    int da[6] = '{5, 7, 15, 0, 12, 1};
    int db[6] = '{3, 15, 15, 9, 0, 1};
    for (int k = 0; k < 6; k++) run_checked("directed", da[k], db[k]);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      run_checked("random", $urandom_range(0, 15), $urandom_range(0, 15));
    end
  endtask

  task automatic test_en_hold();
    int lat;
    bit bok;
    int ec;
    ec = exp_cyc(9, 6);
    do_op(9, 6, 10, ec - 1, -1, lat, bok);
    n_vec++;
    if (result !== OW'(54)) begin n_err++; $display("FAIL en_hold_result got=%0d want=54", result); end
    n_vec++;
    if (cyc_cnt !== CW'(ec)) begin n_err++; $display("FAIL en_hold_cyc got=%0d want=%0d", cyc_cnt, ec); end
    n_vec++;
    if (lat != ec + 10) begin n_err++; $display("FAIL en_hold_latency got=%0d want=%0d", lat, ec + 10); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    bit saw_done;
    saw_done = 1'b0;
    en    = 1'b1;
    start = 1'b1;
    op_in = {4'd7, 4'd11};
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || result !== '0 || cyc_cnt !== '0) begin
      n_err++; $display("FAIL abort_clear got busy=%b result=%0d cyc=%0d want 0/0/0", busy, result, cyc_cnt);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    n_vec++;
    if (saw_done) begin n_err++; $display("FAIL abort_no_done got=done seen want=none"); end
    run_checked("after_abort", 2, 2);
  endtask

  task automatic test_start_ignored_back_to_back();
    int lat;
    bit bok;
    do_op(10, 13, 0, R, 30, lat, bok);
    n_vec++;
    if (result !== OW'(130)) begin n_err++; $display("FAIL ignored_start_result got=%0d want=130", result); end
    n_vec++;
    if (cyc_cnt !== CW'(exp_cyc(10, 13))) begin n_err++; $display("FAIL ignored_start_cyc got=%0d want=%0d", cyc_cnt, exp_cyc(10, 13)); end
    n_vec++;
    if (lat != exp_cyc(10, 13)) begin n_err++; $display("FAIL ignored_start_latency got=%0d want=%0d", lat, exp_cyc(10, 13)); end
    @(negedge clk);
    run_checked("back_to_back", 6, 11);
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    start = 1'b0;
    op_in = '0;
    test_reset();
    test_directed();
    test_random();
    test_en_hold();
    test_abort();
    test_start_ignored_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
